// File: rtl/brownout_supervisor.sv
// Brown-out detector back-end: per-channel sync + debounce, masked trip, reloadable one-shot hold.
// Define BROWNOUT_EVT_CNT_EN to build the saturating trip-event counter (brout_cnt, clr_cnt).
module brownout_supervisor #(
    parameter int unsigned NCH          = 2,
    parameter int unsigned FILT_LEN     = 8,
    parameter int unsigned FILT_W       = 4,
    parameter int unsigned HOLD_CYCLES  = 40000,
    parameter int unsigned SHORT_CYCLES = 16,
    parameter int unsigned HOLD_W       = 16
) (
    input  logic             osc_ck,
    input  logic             ena,
    input  logic [NCH-1:0]   dcomp,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             force_short_oneshot,
    input  logic             clr_cnt,
    output logic [NCH-1:0]   brout_filt,
    output logic             vunder,
    output logic             out,
    output logic             timed_out,
    output logic [7:0]       brout_cnt
);

    localparam logic [FILT_W-1:0] FiltMax   = FILT_W'(FILT_LEN - 1);
    localparam logic [HOLD_W-1:0] HoldLoad  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] ShortLoad = HOLD_W'(SHORT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTrip,
        StHold
    } state_e;

    logic [NCH-1:0]    sync1_q, sync2_q;
    logic              vunder_q;
    logic              trip;
    state_e            state_q;
    logic              out_q;
    logic              timed_out_q;
    logic [HOLD_W-1:0] hold_cnt_q;

    // Two-flop synchroniser; dcomp is asynchronous to osc_ck.
    always_ff @(posedge osc_ck) begin
        if (!ena) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dcomp;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge osc_ck) begin
        if (!ena) begin
            vunder_q <= 1'b0;
        end else begin
            vunder_q <= |(sync2_q & ch_mask);
        end
    end

    // Symmetric debounce: the filtered bit follows only after FILT_LEN consecutive mismatches.
    for (genvar i = 0; i < int'(NCH); i++) begin : gen_filt
        logic [FILT_W-1:0] cnt_q;
        logic              filt_q;

        always_ff @(posedge osc_ck) begin
            if (!ena) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync2_q[i] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FiltMax) begin
                filt_q <= sync2_q[i];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign brout_filt[i] = filt_q;
    end

    assign trip = |(brout_filt & ch_mask);

    always_ff @(posedge osc_ck) begin
        if (!ena) begin
            state_q     <= StIdle;
            out_q       <= 1'b0;
            timed_out_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            timed_out_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trip) begin
                        state_q <= StTrip;
                        out_q   <= 1'b1;
                    end
                end
                StTrip: begin
                    out_q <= 1'b1;
                    if (!trip) begin
                        state_q    <= StHold;
                        hold_cnt_q <= force_short_oneshot ? ShortLoad : HoldLoad;
                    end
                end
                StHold: begin
                    // Re-trigger wins over expiry.
                    if (trip) begin
                        state_q <= StTrip;
                        out_q   <= 1'b1;
                    end else if (hold_cnt_q == '0) begin
                        state_q     <= StIdle;
                        out_q       <= 1'b0;
                        timed_out_q <= 1'b1;
                    end else begin
                        out_q      <= 1'b1;
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign vunder    = vunder_q;
    assign out       = out_q;
    assign timed_out = timed_out_q;

`ifdef BROWNOUT_EVT_CNT_EN
    logic       evt_inc;
    logic [7:0] evt_cnt_q;

    // Any entry into TRIP, from IDLE or as a HOLD re-trigger.
    assign evt_inc = trip && (state_q != StTrip);

    always_ff @(posedge osc_ck) begin
        if (!ena) begin
            evt_cnt_q <= '0;
        end else if (clr_cnt) begin
            evt_cnt_q <= '0;
        end else if (evt_inc && (evt_cnt_q != 8'hff)) begin
            evt_cnt_q <= evt_cnt_q + 1'b1;
        end
    end

    assign brout_cnt = evt_cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign brout_cnt      = '0;
`endif

endmodule

// File: tb/tb_brownout_supervisor.sv
// Randomised bench for brownout_supervisor against a cycle-level behavioural model.
module tb_brownout_supervisor;

    localparam int NCH      = 2;
    localparam int FILT_LEN = 8;
    localparam int FILT_W   = 4;
    localparam int HOLD     = 40;
    localparam int SHORT    = 16;
    localparam int HOLD_W   = 16;
`ifdef BROWNOUT_EVT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic           osc_ck;
    logic           ena;
    logic [NCH-1:0] dcomp;
    logic [NCH-1:0] ch_mask;
    logic           force_short_oneshot;
    logic           clr_cnt;
    logic [NCH-1:0] brout_filt;
    logic           vunder;
    logic           out;
    logic           timed_out;
    logic [7:0]     brout_cnt;

    brownout_supervisor #(
        .NCH          (NCH),
        .FILT_LEN     (FILT_LEN),
        .FILT_W       (FILT_W),
        .HOLD_CYCLES  (HOLD),
        .SHORT_CYCLES (SHORT),
        .HOLD_W       (HOLD_W)
    ) dut (
        .osc_ck              (osc_ck),
        .ena                 (ena),
        .dcomp               (dcomp),
        .ch_mask             (ch_mask),
        .force_short_oneshot (force_short_oneshot),
        .clr_cnt             (clr_cnt),
        .brout_filt          (brout_filt),
        .vunder              (vunder),
        .out                 (out),
        .timed_out           (timed_out),
        .brout_cnt           (brout_cnt)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    int n_vec = 0;
    int n_err = 0;

    // Model: sync pipeline, run length of mismatches per channel, trip/hold bookkeeping.
    logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_filt = '0;
    int             m_run [NCH];
    logic           m_vunder = 1'b0;
    bit             m_in_trip = 1'b0;
    int             m_hold_left = 0;
    logic           m_to = 1'b0;
    int             m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit entry_pending();
        return (|(m_filt & ch_mask)) && !m_in_trip;
    endfunction

    task automatic model_update();
        logic [NCH-1:0] nf;
        bit             trip;
        bit             evt;
        if (!ena) begin
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_vunder = 1'b0;
            m_in_trip = 1'b0; m_hold_left = 0; m_to = 1'b0; m_cnt = 0;
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
            return;
        end
        trip = |(m_filt & ch_mask);
        evt  = 1'b0;
        m_vunder = |(m_s2 & ch_mask);
        nf = m_filt;
        for (int i = 0; i < NCH; i++) begin
            if (m_s2[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == FILT_LEN) begin
                    nf[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_to = 1'b0;
        if (trip) begin
            if (!m_in_trip) evt = 1'b1;
            m_in_trip = 1'b1;
            m_hold_left = 0;
        end else if (m_in_trip) begin
            m_in_trip = 1'b0;
            m_hold_left = force_short_oneshot ? SHORT : HOLD;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_to = 1'b1;
        end
        if (CntEn) begin
            if (clr_cnt) m_cnt = 0;
            else if (evt && m_cnt < 255) m_cnt++;
        end
        m_filt = nf;
        m_s2 = m_s1;
        m_s1 = dcomp;
    endtask

    task automatic step();
        @(posedge osc_ck);
        model_update();
        #1;
        check("brout_filt", 32'(brout_filt), 32'(m_filt));
        check("vunder", 32'(vunder), 32'(m_vunder));
        check("out", 32'(out), 32'(m_in_trip || m_hold_left > 0));
        check("timed_out", 32'(timed_out), 32'(m_to));
        check("brout_cnt", 32'(brout_cnt), 32'(m_cnt));
    endtask

    task automatic settle();
        dcomp = '0;
        repeat (FILT_LEN + HOLD + 10) step();
    endtask

    initial begin
        int  got;
        int  pulses;
        bit  dropped;
        int  dur;

        for (int i = 0; i < NCH; i++) m_run[i] = 0;
        ena = 1'b0; dcomp = '1; ch_mask = '1; force_short_oneshot = 1'b0; clr_cnt = 1'b0;
        @(negedge osc_ck);

        // Reset held with comparators asserted.
        repeat (3) step();
        check("rst_out", 32'(out), 0);
        check("rst_filt", 32'(brout_filt), 0);

        ena = 1'b1;
        got = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (out && got < 0) got = k;
        end
        check("rise_edge", got, 2 + FILT_LEN);
        settle();

        // Short glitch never reaches the filter.
        dcomp = 2'b01;
        repeat (6) step();
        dcomp = '0;
        repeat (20) step();
        check("glitch_filt", 32'(brout_filt), 0);
        check("glitch_out", 32'(out), 0);

        dcomp = 2'b01;
        got = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (brout_filt[0] && got < 0) got = k;
        end
        check("filt_edge", got, 1 + FILT_LEN);

        // Short one-shot: release-to-fall latency and a single timeout pulse.
        force_short_oneshot = 1'b1;
        dcomp = '0;
        got = -1;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (!out && got < 0) got = k;
            if (timed_out) pulses++;
        end
        check("hold_fall_edge", got, 2 + FILT_LEN + SHORT);
        check("hold_pulses", pulses, 1);
        force_short_oneshot = 1'b0;

        // Re-trigger mid-hold on the other channel.
        dcomp = 2'b01;
        repeat (12) step();
        dcomp = '0;
        repeat (2 + FILT_LEN + 5) step();
        dcomp = 2'b10;
        dropped = 1'b0;
        repeat (25) begin
            step();
            if (!out) dropped = 1'b1;
        end
        check("retrig_drop", 32'(dropped), 0);
        settle();

        // Masking.
        ch_mask = 2'b10;
        dcomp = 2'b01;
        repeat (15) step();
        check("mask_filt0", 32'(brout_filt[0]), 1);
        check("mask_vunder", 32'(vunder), 0);
        check("mask_out", 32'(out), 0);
        ch_mask = 2'b11;
        step();
        check("unmask_out", 32'(out), 1);
        settle();

        // Saturation through repeated re-triggers.
        force_short_oneshot = 1'b1;
        repeat (300) begin
            dcomp = 2'b01;
            repeat (12) step();
            dcomp = '0;
            repeat (12) step();
        end
        check("cnt_sat", 32'(brout_cnt), CntEn ? 255 : 0);
        settle();

        // Clear coincident with a trip entry.
        dcomp = 2'b11;
        for (int k = 0; k < 20; k++) begin
            clr_cnt = entry_pending();
            step();
        end
        clr_cnt = 1'b0;
        check("cnt_clr", 32'(brout_cnt), 0);
        settle();

        // Random traffic, including mid-hold resets.
        for (int seg = 0; seg < 250; seg++) begin
            dcomp = NCH'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) ch_mask = NCH'($urandom_range(0, 3));
            force_short_oneshot = $urandom_range(0, 1) == 1;
            dur = $urandom_range(1, 24);
            repeat (dur) begin
                clr_cnt = $urandom_range(0, 29) == 0;
                ena = $urandom_range(0, 299) != 0;
                step();
            end
        end
        ena = 1'b1;
        clr_cnt = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
